dynamic_noise_filter_top: RTL and testbench

- SPI-slave audio processing block. Receives signed 16-bit PCM samples over SPI and runs each through a dynamic noise gate: envelope follower, adaptive noise-floor tracker and threshold attenuation.
- Returns the processed sample on MISO during the next SPI transfer (full-duplex, one-word latency).
- Sits between an external host or codec and the chip's audio path. All logic runs in the system clock domain.

---
 rtl/dnf_pkg.sv | 39 +++
 rtl/spi_slave_if.sv | 110 +++++++++++
 rtl/dynamic_noise_filter_top.sv | 114 +++++++++++
 tb/tb_dynamic_noise_filter_top.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dnf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dnf_pkg
// Description : Shared types, default constants and helpers for the dynamic
//               noise filter (sample/magnitude types, filter defaults, |x|).
// Revision    : 1.0 - initial release
// ============================================================================
package dnf_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic        [DATA_W-2:0] mag_t;

    // Default filter / interface settings
    localparam int c_env_shift   = 3;
    localparam int c_floor_rise  = 1;
    localparam int c_margin      = 64;
    localparam int c_atten_shift = 3;
    localparam int c_sync_stages = 2;

    localparam mag_t    c_mag_max = '1;
    localparam sample_t c_most_neg = {1'b1, {(DATA_W-1){1'b0}}};

    // Absolute value clipped into the magnitude range; the most negative
    // sample has no positive counterpart and maps to full scale.
    function automatic mag_t abs_sat(input sample_t x);
        logic [DATA_W-1:0] w_neg;
        w_neg = -x;
        if (x == c_most_neg)
            return c_mag_max;
        else if (x[DATA_W-1])
            return w_neg[DATA_W-2:0];
        else
            return x[DATA_W-2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_if
// Description : Mode-0 SPI slave in the clk domain. Synchronises spi_clk,
//               spi_sel and spi_mosi, shifts in one word per selection and
//               shifts out the word supplied on i_out_word.
// Ports       : clk, rst (async, active high)
//               i_spi_clk, i_spi_sel (active low), i_spi_mosi -> o_spi_miso
//               o_sample_valid (1-clk pulse) / o_x : received word
//               i_out_word : word returned during the next transfer
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_if
    import dnf_pkg::*;
#(
    parameter int SYNC_STAGES = c_sync_stages
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_spi_clk,
    input  logic    i_spi_sel,
    input  logic    i_spi_mosi,
    output logic    o_spi_miso,
    input  sample_t i_out_word,
    output logic    o_sample_valid,
    output sample_t o_x
);

    localparam logic [4:0] c_bits = 5'(DATA_W);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sel_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_sel_prev;
    logic [4:0]             r_bit_cnt;
    sample_t                r_rx;
    sample_t                r_tx;
    logic                   r_miso;
    logic                   r_sample_valid;

    logic w_sclk;
    logic w_sel;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_sel_fall;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_sel       = r_sel_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_sel_fall  = ~w_sel & r_sel_prev;

    // Select resets to the idle (deselected) level so a bus that is idle
    // when reset releases produces no spurious falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_sel_sync  <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_sel_prev  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
            r_sel_sync  <= {r_sel_sync[SYNC_STAGES-2:0], i_spi_sel};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_sclk_prev <= w_sclk;
            r_sel_prev  <= w_sel;
        end
    end

    // A bit count of c_bits marks a completed word: all later edges in the
    // same selection are ignored until the next select falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt      <= '0;
            r_rx           <= '0;
            r_tx           <= '0;
            r_miso         <= 1'b0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (w_sel) begin
                r_miso <= 1'b0;
            end else if (w_sel_fall) begin
                r_bit_cnt <= '0;
                r_tx      <= i_out_word;
                r_miso    <= i_out_word[DATA_W-1];
            end else if (r_bit_cnt != c_bits) begin
                if (w_sclk_rise) begin
                    r_rx      <= {r_rx[DATA_W-2:0], w_mosi};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                    if (r_bit_cnt == c_bits - 5'd1)
                        r_sample_valid <= 1'b1;
                end else if (w_sclk_fall) begin
                    r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                    r_miso <= r_tx[DATA_W-2];
                end
            end
        end
    end

    assign o_spi_miso     = r_miso;
    assign o_sample_valid = r_sample_valid;
    assign o_x            = r_rx;

endmodule
`default_nettype wire

// File: rtl/dynamic_noise_filter_top.sv
`default_nettype none
// ============================================================================
// Module      : dynamic_noise_filter_top
// Description : SPI-attached dynamic noise gate. Each received sample drives
//               an envelope follower and a min/rise noise-floor tracker; the
//               sample passes when the envelope exceeds floor + margin and is
//               attenuated otherwise. Result is returned on the next transfer.
// Ports       : clk, reset (async, active high)
//               spi_clk, spi_sel (active low), spi_mosi -> spi_miso
// Revision    : 1.0 - initial release
// ============================================================================
module dynamic_noise_filter_top
    import dnf_pkg::*;
#(
    parameter int ENV_SHIFT   = c_env_shift,
    parameter int FLOOR_RISE  = c_floor_rise,
    parameter int MARGIN      = c_margin,
    parameter int ATTEN_SHIFT = c_atten_shift,
    parameter int SYNC_STAGES = c_sync_stages
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic spi_miso,
    input  logic spi_sel
);

    logic    w_sample_valid;
    sample_t w_x;

    sample_t r_out_word;
    logic    r_s1_valid;
    sample_t r_s1_x;
    mag_t    r_env;
    mag_t    r_floor;

    spi_slave_if #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_spi (
        .clk            (clk),
        .rst            (reset),
        .i_spi_clk      (spi_clk),
        .i_spi_sel      (spi_sel),
        .i_spi_mosi     (spi_mosi),
        .o_spi_miso     (spi_miso),
        .i_out_word     (r_out_word),
        .o_sample_valid (w_sample_valid),
        .o_x            (w_x)
    );

    mag_t               w_a;
    logic signed [16:0] w_diff;
    logic signed [16:0] w_step;
    logic signed [16:0] w_env_sum;
    mag_t               w_env_n;
    logic [15:0]        w_floor_inc;
    mag_t               w_floor_n;
    logic [15:0]        w_thresh_sum;
    mag_t               w_thresh;
    sample_t            w_y;

    // Envelope step is (a - env) >>> ENV_SHIFT in 17-bit signed; the sum
    // always lands between env and a, so it fits back into 15 bits.
    always_comb begin
        w_a          = abs_sat(r_s1_x);
        w_diff       = $signed({2'b00, w_a}) - $signed({2'b00, r_env});
        w_step       = w_diff >>> ENV_SHIFT;
        w_env_sum    = $signed({2'b00, r_env}) + w_step;
        w_env_n      = w_env_sum[DATA_W-2:0];

        w_floor_inc  = {1'b0, r_floor} + 16'(FLOOR_RISE);
        if (w_env_n < r_floor)
            w_floor_n = w_env_n;
        else if (w_floor_inc > {1'b0, c_mag_max})
            w_floor_n = c_mag_max;
        else
            w_floor_n = w_floor_inc[DATA_W-2:0];

        w_thresh_sum = {1'b0, w_floor_n} + 16'(MARGIN);
        if (w_thresh_sum > {1'b0, c_mag_max})
            w_thresh = c_mag_max;
        else
            w_thresh = w_thresh_sum[DATA_W-2:0];

        if (w_env_n > w_thresh)
            w_y = r_s1_x;
        else
            w_y = r_s1_x >>> ATTEN_SHIFT;
    end

    // Stage 1 captures the sample; stage 2 commits filter state, placing
    // the out_word update two clocks after sample_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_env      <= '0;
            r_floor    <= '0;
            r_out_word <= '0;
        end else begin
            r_s1_valid <= w_sample_valid;
            if (w_sample_valid)
                r_s1_x <= w_x;
            if (r_s1_valid) begin
                r_env      <= w_env_n;
                r_floor    <= w_floor_n;
                r_out_word <= w_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dynamic_noise_filter_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_dynamic_noise_filter_top
// Description : Directed self-checking bench for dynamic_noise_filter_top.
//               A behavioural filter model predicts each readback word; the
//               prediction is queued when a sample is sent and compared when
//               the following transfer shifts the result out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dynamic_noise_filter_top;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic spi_clk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_sel = 1'b1;
    logic spi_miso;

    int total = 0;
    int bad = 0;

    logic [15:0] sb_q[$];

    int          m_env;
    int          m_floor;
    logic [15:0] m_out;

    int  valid_cnt = 0;
    logic count_en = 1'b0;

    dynamic_noise_filter_top dut (
        .clk      (clk),
        .reset    (reset),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_sel  (spi_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (count_en && dut.w_sample_valid)
            valid_cnt <= valid_cnt + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_env   = 0;
        m_floor = 0;
        m_out   = 16'h0000;
        sb_q.delete();
    endtask

    task automatic model_step(input logic [15:0] x);
        int xi, a, env_n, floor_n, th, yi;
        xi = $signed(x);
        if (xi == -32768)  a = 32767;
        else if (xi < 0)   a = -xi;
        else               a = xi;
        env_n = m_env + ((a - m_env) >>> 3);
        if (env_n < m_floor) floor_n = env_n;
        else                 floor_n = (m_floor + 1 > 32767) ? 32767 : m_floor + 1;
        th = (floor_n + 64 > 32767) ? 32767 : floor_n + 64;
        if (env_n > th) yi = xi;
        else            yi = xi >>> 3;
        m_env   = env_n;
        m_floor = floor_n;
        m_out   = yi[15:0];
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        spi_sel  = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
    endtask

    // Shifts n bits of tx with spi_sel left low; returns bits seen on MISO.
    task automatic shift_bits(input logic [15:0] tx, input int n, output logic [15:0] rx);
        rx = 16'h0000;
        spi_sel = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[15-i];
            repeat (5) @(negedge clk);
            rx[15-i] = spi_miso;
            spi_clk = 1'b1;
            repeat (5) @(negedge clk);
            spi_clk = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic xfer(input string tag, input logic [15:0] tx, output logic [15:0] rx);
        logic [15:0] exp;
        sb_q.push_back(m_out);
        model_step(tx);
        shift_bits(tx, 16, rx);
        spi_sel = 1'b1;
        repeat (10) @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 16'h0001, 16'h0000);
        end else begin
            exp = sb_q.pop_front();
            check(tag, rx, exp);
        end
    endtask

    initial begin
        logic [15:0] rx;

        // Basic pass-through of a loud sample
        do_reset();
        check("reset_miso", {15'd0, spi_miso}, 16'h0000);
        xfer("first_word", 16'h03E8, rx);
        check("first_word_const", rx, 16'h0000);
        xfer("pass_1000", 16'h0000, rx);
        check("pass_1000_const", rx, 16'h03E8);

        // Quiet sample is attenuated
        do_reset();
        xfer("q40_first", 16'd40, rx);
        xfer("gate_40", 16'h0000, rx);
        check("gate_40_const", rx, 16'h0005);

        // Most negative sample saturates |x| and passes
        do_reset();
        xfer("neg_first", 16'h8000, rx);
        xfer("neg_full", 16'h0000, rx);
        check("neg_full_const", rx, 16'h8000);

        // Envelope rise and decay sequence
        do_reset();
        xfer("seq0", 16'd1000, rx);
        xfer("seq1", 16'd1000, rx);
        xfer("seq2", 16'd1000, rx);
        xfer("seq3", 16'd0, rx);
        xfer("seq4", 16'd0, rx);
        xfer("seq5", 16'd0, rx);
        check("seq5_const", rx, 16'h0000);

        // Aborted partial word leaves filter state untouched
        do_reset();
        shift_bits(16'h7FFF, 8, rx);
        spi_sel = 1'b1;
        repeat (10) @(negedge clk);
        xfer("abort_next", 16'd1000, rx);
        xfer("abort_rb", 16'h0000, rx);
        check("abort_rb_const", rx, 16'h03E8);

        // Free-running clock while deselected
        begin
            int miso_hi;
            miso_hi   = 0;
            valid_cnt = 0;
            count_en  = 1'b1;
            spi_sel   = 1'b1;
            for (int i = 0; i < 50; i++) begin
                spi_mosi = i[0];
                spi_clk = 1'b1;
                repeat (4) @(negedge clk);
                if (spi_miso !== 1'b0) miso_hi++;
                spi_clk = 1'b0;
                repeat (4) @(negedge clk);
                if (spi_miso !== 1'b0) miso_hi++;
            end
            repeat (6) @(negedge clk);
            count_en = 1'b0;
            check("freerun_valid", 16'(valid_cnt), 16'h0000);
            check("freerun_miso", 16'(miso_hi), 16'h0000);
        end
        xfer("freerun_state", 16'd1000, rx);

        // Reset in the middle of a transfer
        shift_bits(16'h1234, 8, rx);
        check("pre_reset_miso", {15'd0, spi_miso}, 16'h0001);
        reset = 1'b1;
        #1;
        check("midreset_miso", {15'd0, spi_miso}, 16'h0000);
        @(negedge clk);
        spi_sel = 1'b1;
        spi_clk = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
        xfer("after_reset", 16'd1000, rx);
        check("after_reset_const", rx, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
